// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute FSM with a bounded memory
// handshake wait that falls into a sticky FAULT state on timeout.
`default_nettype none

module control_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        memReady,
    input  logic        zeroFlag,
    output logic        marEn,
    output logic        marSel,
    output logic        memRead,
    output logic        memWrite,
    output logic        irEn,
    output logic        pcInc,
    output logic        pcLoad,
    output logic        regWrite,
    output logic [1:0]  wbSel,
    output logic [3:0]  aluOp,
    output logic [3:0]  regDst,
    output logic [3:0]  regSrc,
    output logic [7:0]  imm,
    output logic        halted,
    output logic        fault,
    output logic        illegal
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_FETCHW = 4'd2;
    localparam logic [3:0] S_DECODE = 4'd3;
    localparam logic [3:0] S_EXEC   = 4'd4;
    localparam logic [3:0] S_MEMA   = 4'd5;
    localparam logic [3:0] S_MEMW   = 4'd6;
    localparam logic [3:0] S_HALT   = 4'd7;
    localparam logic [3:0] S_FAULT  = 4'd8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] w_op;
    logic       w_is_alu;
    logic       w_timeout;

    assign w_op      = instruction[15:12];
    assign w_is_alu  = (w_op >= 4'h1) && (w_op <= 4'h4);
    // The low cycle that would bring the count to TIMEOUT is the last one allowed.
    assign w_timeout = !memReady && ((cnt_q + 8'd1) == TIMEOUT_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                state_d = S_FETCHW;
                cnt_d   = 8'd0;
            end
            S_FETCHW: begin
                if (memReady)       state_d = S_DECODE;
                else if (w_timeout) state_d = S_FAULT;
                else                cnt_d   = cnt_q + 8'd1;
            end
            S_DECODE: begin
                if (w_is_alu || w_op == OP_LDI)          state_d = S_EXEC;
                else if (w_op == OP_LD || w_op == OP_ST) state_d = S_MEMA;
                else if (w_op == OP_HALT)                state_d = S_HALT;
                else                                     state_d = S_FETCH;
            end
            S_EXEC: state_d = S_FETCH;
            S_MEMA: begin
                state_d = S_MEMW;
                cnt_d   = 8'd0;
            end
            S_MEMW: begin
                if (memReady)       state_d = S_FETCH;
                else if (w_timeout) state_d = S_FAULT;
                else                cnt_d   = cnt_q + 8'd1;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        marEn    = 1'b0;
        marSel   = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        irEn     = 1'b0;
        pcInc    = 1'b0;
        pcLoad   = 1'b0;
        regWrite = 1'b0;
        wbSel    = 2'd0;
        aluOp    = 4'd0;
        halted   = 1'b0;
        fault    = 1'b0;
        illegal  = 1'b0;
        regDst   = instruction[11:8];
        regSrc   = instruction[7:4];
        imm      = instruction[7:0];
        case (state_q)
            S_FETCH: marEn = 1'b1;
            S_FETCHW: begin
                memRead = 1'b1;
                irEn    = memReady;
                pcInc   = memReady;
            end
            S_DECODE: begin
                pcLoad  = (w_op == OP_JMP) || (w_op == OP_BZ && zeroFlag);
                illegal = (w_op >= 4'hA) && (w_op <= 4'hE);
            end
            S_EXEC: begin
                regWrite = 1'b1;
                aluOp    = w_is_alu ? w_op : 4'd0;
                wbSel    = (w_op == OP_LDI) ? 2'd1 : 2'd0;
            end
            S_MEMA: begin
                marEn  = 1'b1;
                marSel = 1'b1;
            end
            S_MEMW: begin
                memRead  = (w_op != OP_ST);
                memWrite = (w_op == OP_ST);
                regWrite = memReady && (w_op != OP_ST);
                wbSel    = (memReady && w_op != OP_ST) ? 2'd2 : 2'd0;
            end
            default: begin
                // IDLE, HALT and FAULT present nothing but their status bit.
                regDst = 4'd0;
                regSrc = 4'd0;
                imm    = 8'd0;
                halted = (state_q == S_HALT);
                fault  = (state_q == S_FAULT);
            end
        endcase
    end

    logic w_unused;
    assign w_unused = (w_op == OP_NOP);

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected traces built from the
// instruction-level rules and compared cycle by cycle.
`default_nettype none

module tb_control_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = 16'h0;
    logic        memReady = 1'b0;
    logic        zeroFlag = 1'b0;
    logic        marEn, marSel, memRead, memWrite, irEn, pcInc, pcLoad, regWrite;
    logic [1:0]  wbSel;
    logic [3:0]  aluOp, regDst, regSrc;
    logic [7:0]  imm;
    logic        halted, fault, illegal;

    control_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .memReady(memReady),
        .zeroFlag(zeroFlag), .marEn(marEn), .marSel(marSel), .memRead(memRead),
        .memWrite(memWrite), .irEn(irEn), .pcInc(pcInc), .pcLoad(pcLoad),
        .regWrite(regWrite), .wbSel(wbSel), .aluOp(aluOp), .regDst(regDst),
        .regSrc(regSrc), .imm(imm), .halted(halted), .fault(fault), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        mr;
        logic        zf;
        logic [32:0] exp;
    } step_t;

    step_t       q[$];
    logic [15:0] cur;

    wire [32:0] act = {marEn, marSel, memRead, memWrite, irEn, pcInc, pcLoad, regWrite,
                       wbSel, aluOp, regDst, regSrc, imm, halted, fault, illegal};

    function automatic logic [32:0] ov(input logic ma, ms, rd, wr, ir, inc, ld, rw,
                                       input logic [1:0] wb, input logic [3:0] alu,
                                       input logic pt, h, f, il);
        logic [15:0] p;
        p = pt ? {cur[11:8], cur[7:4], cur[7:0]} : 16'h0;
        return {ma, ms, rd, wr, ir, inc, ld, rw, wb, alu, p, h, f, il};
    endfunction

    task automatic check(input string tag, input logic [32:0] e);
        n_chk++;
        assert (act === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, e);
        end
    endtask

    task automatic push(input logic mr, input logic zf, input logic [32:0] e);
        q.push_back({mr, zf, e});
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            memReady = 1'($urandom);
            @(negedge clk);
            check("reset_idle", 33'h0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Called one tick after the edge that enters FETCH.
    task automatic run_instr(input logic [15:0] ins, input logic zf, input int nf,
                             input int nm, input int rst_at);
        logic [3:0] op;
        logic       rd, wr, lbr, il;
        int         term;
        cur  = ins;
        op   = ins[15:12];
        term = 0;
        q.delete();
        instruction = ins;
        push(1'($urandom), 1'($urandom), ov(1,0,0,0,0,0,0,0,2'd0,4'd0,1,0,0,0));
        if (nf >= TO) begin
            repeat (TO) push(1'b0, 1'($urandom), ov(0,0,1,0,0,0,0,0,2'd0,4'd0,1,0,0,0));
            term = 2;
        end else begin
            repeat (nf) push(1'b0, 1'($urandom), ov(0,0,1,0,0,0,0,0,2'd0,4'd0,1,0,0,0));
            push(1'b1, 1'($urandom), ov(0,0,1,0,1,1,0,0,2'd0,4'd0,1,0,0,0));
            lbr = (op == 4'h8) || (op == 4'h9 && zf);
            il  = (op >= 4'hA) && (op <= 4'hE);
            push(1'($urandom), zf, ov(0,0,0,0,0,0,lbr,0,2'd0,4'd0,1,0,0,il));
            if (op >= 4'h1 && op <= 4'h4) begin
                push(1'($urandom), 1'($urandom), ov(0,0,0,0,0,0,0,1,2'd0,op,1,0,0,0));
            end else if (op == 4'h5) begin
                push(1'($urandom), 1'($urandom), ov(0,0,0,0,0,0,0,1,2'd1,4'd0,1,0,0,0));
            end else if (op == 4'h6 || op == 4'h7) begin
                rd = (op == 4'h6);
                wr = (op == 4'h7);
                push(1'($urandom), 1'($urandom), ov(1,1,0,0,0,0,0,0,2'd0,4'd0,1,0,0,0));
                if (nm >= TO) begin
                    repeat (TO) push(1'b0, 1'($urandom), ov(0,0,rd,wr,0,0,0,0,2'd0,4'd0,1,0,0,0));
                    term = 2;
                end else begin
                    repeat (nm) push(1'b0, 1'($urandom), ov(0,0,rd,wr,0,0,0,0,2'd0,4'd0,1,0,0,0));
                    push(1'b1, 1'($urandom), ov(0,0,rd,wr,0,0,0,rd,rd ? 2'd2 : 2'd0,4'd0,1,0,0,0));
                end
            end else if (op == 4'hF) begin
                term = 1;
            end
        end

        foreach (q[i]) begin
            memReady = q[i].mr;
            zeroFlag = q[i].zf;
            reset    = (i == rst_at);
            @(negedge clk);
            check($sformatf("op%h_step%0d", op, i), q[i].exp);
            @(posedge clk); #1;
            if (i == rst_at) begin
                reset    = 1'b0;
                memReady = 1'($urandom);
                @(negedge clk);
                check($sformatf("op%h_midreset", op), 33'h0);
                @(posedge clk); #1;
                return;
            end
        end

        if (term != 0) begin
            repeat (term == 1 ? 20 : 8) begin
                instruction = 16'($urandom);
                memReady    = 1'($urandom);
                zeroFlag    = 1'($urandom);
                @(negedge clk);
                check(term == 1 ? "halt_hold" : "fault_hold",
                      ov(0,0,0,0,0,0,0,0,2'd0,4'd0,0,term == 1,term == 2,0));
                @(posedge clk); #1;
            end
            do_reset(1 + int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] ins;
        int          nf, nm, ra;
        do_reset(2);
        run_instr(16'h1230, 1'b0, 0, 0, -1);
        run_instr(16'h6140, 1'b0, 0, 3, -1);
        run_instr(16'h9020, 1'b1, 1, 0, -1);
        run_instr(16'h9020, 1'b0, 0, 0, -1);
        run_instr(16'hA000, 1'b0, 2, 0, -1);
        run_instr(16'h7150, 1'b0, 0, 3, 5);
        run_instr(16'h5107, 1'b0, 3, 0, -1);
        run_instr(16'h4ABC, 1'b0, 0, 0, -1);
        run_instr(16'h0000, 1'b1, TO, 0, -1);
        run_instr(16'h6200, 1'b0, 0, TO, -1);
        run_instr(16'h7310, 1'b0, TO - 1, TO - 1, -1);
        run_instr(16'hF000, 1'b0, 0, 0, -1);
        run_instr(16'h8055, 1'b0, 0, 0, -1);

        for (int k = 0; k < 150; k++) begin
            op  = 4'($urandom);
            ins = {op, 12'($urandom)};
            nf  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 2))
                                              : int'($urandom_range(0, TO - 1));
            nm  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 2))
                                              : int'($urandom_range(0, TO - 1));
            ra  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr(ins, 1'($urandom), nf, nm, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
